// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between hazard detection / fetch and the IF/ID + ID/EX stall controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] instr_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              pc_we_o;
  logic [DATA_W-1:0] ifid_pc_o;
  logic [DATA_W-1:0] ifid_instr_o;
  logic              ifid_valid_o;
  logic [CTRL_W-1:0] idex_ctrl_o;
  logic              idex_bubble_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic              stall_err_o;

  modport master (
    output stall_i, flush_i, pc_i, instr_i, ctrl_i,
    input  pc_we_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, idex_ctrl_o, idex_bubble_o,
    input  stall_cnt_o, flush_cnt_o, stall_err_o
  );

  modport slave (
    input  stall_i, flush_i, pc_i, instr_i, ctrl_i,
    output pc_we_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, idex_ctrl_o, idex_bubble_o,
    output stall_cnt_o, flush_cnt_o, stall_err_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// IF/ID register and ID/EX control half with stall/flush handling, saturating event
// counters and a stuck-stall watchdog.
module pipe_stall_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CTRL_W    = 10,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  pipe_stall_ctrl_if.slave   bus
);
  localparam int unsigned WdW = $clog2(MAX_STALL + 2);

  logic [DATA_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic              idex_bubble_q, idex_bubble_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              stall_err_q, stall_err_d;
  logic [WdW-1:0]    run_q, run_d;
  logic              advance;

  assign bus.pc_we_o = ~rst_i & (~bus.stall_i | bus.flush_i);

  always_comb begin
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    idex_ctrl_d   = '0;
    idex_bubble_d = 1'b1;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    stall_err_d   = stall_err_q;
    run_d         = '0;
    // On a flush the branch in ID still moves to EX unless it is itself stalled.
    advance       = ifid_valid_q & ~(bus.flush_i & bus.stall_i);

    if (bus.flush_i) begin
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (bus.stall_i) begin
      advance = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
      run_d = (run_q == WdW'(MAX_STALL + 1)) ? run_q : run_q + 1'b1;
      if (run_q >= WdW'(MAX_STALL)) stall_err_d = 1'b1;
    end else begin
      ifid_pc_d    = bus.pc_i;
      ifid_instr_d = bus.instr_i;
      ifid_valid_d = 1'b1;
    end

    if (advance) begin
      idex_ctrl_d   = bus.ctrl_i;
      idex_bubble_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_pc_q     <= '0;
      ifid_instr_q  <= '0;
      ifid_valid_q  <= 1'b0;
      idex_ctrl_q   <= '0;
      idex_bubble_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      stall_err_q   <= 1'b0;
      run_q         <= '0;
    end else begin
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      idex_ctrl_q   <= idex_ctrl_d;
      idex_bubble_q <= idex_bubble_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_err_q   <= stall_err_d;
      run_q         <= run_d;
    end
  end

  assign bus.ifid_pc_o     = ifid_pc_q;
  assign bus.ifid_instr_o  = ifid_instr_q;
  assign bus.ifid_valid_o  = ifid_valid_q;
  assign bus.idex_ctrl_o   = idex_ctrl_q;
  assign bus.idex_bubble_o = idex_bubble_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;
  assign bus.stall_err_o   = stall_err_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed plus randomized bench for pipe_stall_ctrl against a behavioural pipeline model.
module tb_pipe_stall_ctrl;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CTRL_W    = 10;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MAX_STALL = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what each pipeline slot should contain, counters as plain integers.
  logic [DATA_W-1:0] m_pc, m_instr;
  logic              m_valid, m_bubble, m_err;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_scnt, m_fcnt, m_run;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_step();
    logic moves;
    if (rst) begin
      m_pc = '0; m_instr = '0; m_valid = 0; m_ctrl = '0; m_bubble = 0;
      m_scnt = 0; m_fcnt = 0; m_run = 0; m_err = 0;
    end else if (bus.flush_i) begin
      moves    = m_valid && !bus.stall_i;
      m_ctrl   = moves ? bus.ctrl_i : '0;
      m_bubble = !moves;
      m_pc = '0; m_instr = '0; m_valid = 0;
      m_fcnt   = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
      m_run    = 0;
    end else if (bus.stall_i) begin
      m_ctrl   = '0;
      m_bubble = 1;
      m_scnt   = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
      m_run    = m_run + 1;
      if (m_run > MAX_STALL) m_err = 1;
    end else begin
      m_ctrl   = m_valid ? bus.ctrl_i : '0;
      m_bubble = !m_valid;
      m_pc     = bus.pc_i;
      m_instr  = bus.instr_i;
      m_valid  = 1;
      m_run    = 0;
    end
  endtask

  task automatic check_all();
    check("ifid_pc",     64'(bus.ifid_pc_o),     64'(m_pc));
    check("ifid_instr",  64'(bus.ifid_instr_o),  64'(m_instr));
    check("ifid_valid",  64'(bus.ifid_valid_o),  64'(m_valid));
    check("idex_ctrl",   64'(bus.idex_ctrl_o),   64'(m_ctrl));
    check("idex_bubble", 64'(bus.idex_bubble_o), 64'(m_bubble));
    check("stall_cnt",   64'(bus.stall_cnt_o),   64'(m_scnt));
    check("flush_cnt",   64'(bus.flush_cnt_o),   64'(m_fcnt));
    check("stall_err",   64'(bus.stall_err_o),   64'(m_err));
  endtask

  // One clock: drive inputs, check pc_we before the edge, then the registered outputs after.
  task automatic cycle(input logic r, input logic s, input logic f,
                       input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] instr,
                       input logic [CTRL_W-1:0] ctrl, input bit chk);
    rst = r; bus.stall_i = s; bus.flush_i = f;
    bus.pc_i = pc; bus.instr_i = instr; bus.ctrl_i = ctrl;
    #1;
    if (chk) check("pc_we", 64'(bus.pc_we_o), 64'(!r && (!s || f)));
    @(posedge clk);
    model_step();
    #1;
    if (chk) check_all();
  endtask

  logic [DATA_W-1:0] prog [3];

  initial begin
    prog[0] = 32'h8C01_0004; prog[1] = 32'h0022_1820; prog[2] = 32'h0000_0000;
    rst = 1; bus.stall_i = 0; bus.flush_i = 0;
    bus.pc_i = '0; bus.instr_i = '0; bus.ctrl_i = '0;
    @(posedge clk); #1;

    // Reset state
    cycle(1, 0, 0, 32'h4, 32'h1234_5678, 10'h3FF, 1);
    // Straight-line fetch of three instructions
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'(4 * (i + 1)), prog[i], 10'(i + 1), 1);
    // Single stall holding IF/ID, then stall+flush together
    cycle(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 10'h155, 1);
    cycle(0, 1, 1, 32'h14, 32'hCAFE_F00D, 10'h0AA, 1);
    cycle(0, 0, 0, 32'h18, prog[0], 10'h011, 1);
    // Watchdog: MAX_STALL+1 consecutive stalls, then release
    for (int i = 0; i < MAX_STALL + 1; i++) cycle(0, 1, 0, 32'h1C, 32'h1, 10'h022, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'(32 + 4 * i), 32'h2, 10'h033, 1);
    // Reset during a stall
    cycle(1, 1, 0, 32'h40, 32'h3, 10'h044, 1);
    cycle(0, 0, 0, 32'h44, 32'h4, 10'h055, 1);

    // Stall counter saturation
    cycle(1, 0, 0, '0, '0, '0, 1);
    for (int i = 0; i < CNT_MAX; i++) cycle(0, 1, 0, '0, '0, '0, 0);
    check_all();
    cycle(0, 1, 0, 32'h8, 32'h9, 10'h1, 1);
    cycle(0, 1, 1, 32'h8, 32'h9, 10'h1, 1);

    // Randomized traffic with occasional resets
    cycle(1, 0, 0, '0, '0, '0, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 2, $urandom_range(99) < 35, $urandom_range(99) < 12,
            $urandom, $urandom, CTRL_W'($urandom), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
